// File: rtl/divisor.sv
// divisor: sequential restoring divider, one quotient bit per clock.
// Takes a 2*TAM-bit dividend and a TAM-bit divisor.
// Returns a 2*TAM-bit quotient and a TAM-bit remainder with a start/busy/done handshake.
// A zero divisor returns an all-ones quotient, a zero remainder and div_zero=1.
module divisor #(
   parameter int TAM = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*TAM-1:0]   S,
   input  logic [TAM-1:0]     B,
   output logic [2*TAM-1:0]   Q,
   output logic [TAM-1:0]     R,
   output logic               busy,
   output logic               done,
   output logic               div_zero
);

   localparam int            CW   = $clog2(2*TAM);
   localparam logic [CW-1:0] LAST = CW'(2*TAM-1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q, state_d;
   logic [TAM:0]       rem_q, rem_d;       // partial remainder, one guard bit
   logic [2*TAM-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
   logic [TAM-1:0]     b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               zdiv_q, zdiv_d;     // current operation is a divide-by-zero
   logic [2*TAM-1:0]   q_q, q_d;
   logic [TAM-1:0]     r_q, r_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   // One shift-subtract step: move the next dividend bit into the remainder, then try B.
   logic [TAM:0]       sh_rem;
   logic [TAM:0]       sub_rem;
   logic [2*TAM-1:0]   sh_quo;
   logic               fits;

   assign sh_rem  = {rem_q[TAM-1:0], quo_q[2*TAM-1]};
   assign sub_rem = sh_rem - {1'b0, b_q};
   assign sh_quo  = {quo_q[2*TAM-2:0], 1'b0};
   assign fits    = (sh_rem >= {1'b0, b_q});

   // Next-state and datapath: accept in IDLE/FIN, iterate in RUN, publish results on completion.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      zdiv_d  = zdiv_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;

      case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               dz_d    = (B == '0);
               if (B != '0) begin
                  quo_d  = S;
                  b_d    = B;
                  rem_d  = '0;
                  cnt_d  = '0;
                  zdiv_d = 1'b0;
                  busy_d = 1'b1;
               end else begin
                  // Divide-by-zero spends a single non-busy cycle in RUN before FIN.
                  zdiv_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (zdiv_q) begin
               q_d     = '1;
               r_d     = '0;
               done_d  = 1'b1;
               state_d = FIN;
            end else begin
               rem_d = fits ? sub_rem : sh_rem;
               quo_d = {sh_quo[2*TAM-1:1], fits};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  q_d     = {sh_quo[2*TAM-1:1], fits};
                  r_d     = fits ? sub_rem[TAM-1:0] : sh_rem[TAM-1:0];
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FIN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything, even mid-division.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         zdiv_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         zdiv_q  <= zdiv_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign Q        = q_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor.sv
// tb_divisor: directed and random checks of divisor (TAM=8) against integer / and %.
module tb_divisor;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] S;
   logic [7:0]  B;
   logic [15:0] Q;
   logic [7:0]  R;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   divisor #(.TAM(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .S        (S),
      .B        (B),
      .Q        (Q),
      .R        (R),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until done is seen or the cycle budget expires; n counts edges taken.
   task automatic wait_done(output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (done !== 1'b1 && n < 200) begin
         if (busy === 1'b1) nbusy++;
         step();
         n++;
      end
   endtask

   // One complete operation checked against plain integer division.
   task automatic run_op(input logic [15:0] s, input logic [7:0] b);
      int          n, nb, lat, exp_busy;
      logic [15:0] eq;
      logic [7:0]  er;
      if (b == 8'd0) begin
         eq = 16'hFFFF; er = 8'd0; lat = 1;  exp_busy = 0;
      end else begin
         eq = s / 16'(b);
         er = 8'(s % 16'(b));
         lat = 16; exp_busy = 16;
      end
      S = s; B = b; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n, nb);
      check("latency", 32'(n), 32'(lat));
      check("busy_cycles", 32'(nb), 32'(exp_busy));
      check("busy_at_done", 32'(busy), 32'd0);
      check("quotient", 32'(Q), 32'(eq));
      check("remainder", 32'(R), 32'(er));
      check("div_zero", 32'(div_zero), 32'(b == 8'd0));
      if (b != 8'd0) begin
         check("invariant", 32'(Q) * 32'(b) + 32'(R), 32'(s));
         check("r_lt_b", 32'(R < b), 32'd1);
      end
      step();
      check("done_one_cycle", 32'(done), 32'd0);
      check("q_hold", 32'(Q), 32'(eq));
   endtask

   initial begin
      int          n, nb;
      logic [15:0] rs;
      logic [7:0]  rb;

      rst_n = 1'b0; start = 1'b0; S = '0; B = '0;
      #12;
      check("rst_q", 32'(Q), 32'd0);
      check("rst_r", 32'(R), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Directed values and boundaries.
      run_op(16'd1000, 8'd7);
      run_op(16'd65535, 8'd255);
      run_op(16'd65535, 8'd1);
      run_op(16'd5, 8'd9);
      run_op(16'd0, 8'd200);
      run_op(16'd1234, 8'd0);
      run_op(16'd10, 8'd3);

      // start/S/B changes during RUN are ignored; start held through FIN is taken back-to-back.
      S = 16'd1000; B = 8'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      S = 16'd9; B = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      check("ignore_busy", 32'(busy), 32'd1);
      wait_done(n, nb);
      check("ignore_latency", 32'(n + 6), 32'd16);
      check("ignore_q", 32'(Q), 32'd142);
      check("ignore_r", 32'(R), 32'd6);
      start = 1'b1;
      step();
      start = 1'b0;
      check("b2b_done_drop", 32'(done), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done(n, nb);
      check("b2b_latency", 32'(n), 32'd16);
      check("b2b_q", 32'(Q), 32'd3);
      check("b2b_r", 32'(R), 32'd0);
      step();

      // Asynchronous reset in the middle of a division.
      S = 16'd1000; B = 8'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) step();
      #3 rst_n = 1'b0;
      #1;
      check("arst_q", 32'(Q), 32'd0);
      check("arst_r", 32'(R), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_dz", 32'(div_zero), 32'd0);
      step();
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) break;
      end
      check("arst_no_done", 32'(done), 32'd0);
      check("arst_idle", 32'(busy), 32'd0);
      run_op(16'd300, 8'd17);

      // Random sweep with nonzero divisors.
      for (int k = 0; k < 1000; k++) begin
         rs = 16'($urandom_range(0, 65535));
         rb = 8'($urandom_range(1, 255));
         run_op(rs, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
